pht_predictor: RTL and testbench

- Pattern history table (PHT) for the branch predictor: an array of 2-bit saturating counters.
- Fetch side: indexed lookup with a 1-cycle registered prediction.
- Resolve side: pipelined read-modify-write path that supplies the current counter state and writes back the saturated next state.
- Sits between fetch (lookup) and EX/branch resolution (update); owns all counter storage.

---
 rtl/pht_predictor_pkg.sv | 15 +
 rtl/pht_predictor_if.sv | 25 ++
 rtl/pht_predictor_sat_update.sv | 19 +
 rtl/pht_predictor.sv | 103 ++++++++++
 tb/tb_pht_predictor.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pht_predictor_pkg.sv
// Shared types and constants for the pattern history table predictor.
package pht_pkg;

  localparam int PC_W_DFLT      = 32;
  localparam int PHT_IDX_W_DFLT = 7;

  typedef logic [1:0] pht_ctr_t;

  localparam pht_ctr_t CTR_SNT   = 2'b00;
  localparam pht_ctr_t CTR_WNT   = 2'b01;
  localparam pht_ctr_t CTR_WT    = 2'b10;
  localparam pht_ctr_t CTR_ST    = 2'b11;
  localparam pht_ctr_t CTR_RESET = CTR_WNT;

endpackage

// File: rtl/pht_predictor_if.sv
// Fetch-lookup and resolve-update signal bundle; the predictor is the slave side.
interface pht_predictor_if #(
  parameter int PC_W      = 32,
  parameter int PHT_IDX_W = 7
);
  logic                 pred_valid;
  logic [PC_W-1:0]      pred_pc;
  logic                 pred_resp;
  logic                 pred_taken;
  logic [PHT_IDX_W-1:0] pred_idx;
  logic                 upd_valid;
  logic [PHT_IDX_W-1:0] upd_idx;
  logic                 upd_taken;
  logic                 upd_busy;

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_idx, upd_taken,
    input  pred_resp, pred_taken, pred_idx, upd_busy
  );

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_idx, upd_taken,
    output pred_resp, pred_taken, pred_idx, upd_busy
  );
endinterface

// File: rtl/pht_predictor_sat_update.sv
// Two-bit saturating counter step: taken counts up to 11, not-taken down to 00.
module pht_sat_update
  import pht_pkg::*;
(
  input  pht_ctr_t cur_i,
  input  logic     taken_i,
  output pht_ctr_t next_o
);

  always_comb begin
    next_o = cur_i;
    if (taken_i) begin
      if (cur_i != CTR_ST) next_o = cur_i + 2'd1;
    end else begin
      if (cur_i != CTR_SNT) next_o = cur_i - 2'd1;
    end
  end

endmodule

// File: rtl/pht_predictor.sv
// PHT with registered lookup and a U0/U1/U2 read-modify-write update pipe.
// Define PHT_GSHARE_EN to XOR the PC index with non-speculative global history.
module pht_predictor
  import pht_pkg::*;
#(
  parameter int PC_W      = PC_W_DFLT,
  parameter int PHT_IDX_W = PHT_IDX_W_DFLT
) (
  input logic            clk,
  input logic            rst,
  pht_predictor_if.slave bus
);

  localparam int DEPTH = 1 << PHT_IDX_W;
  typedef logic [PHT_IDX_W-1:0] idx_t;

  pht_ctr_t table_q [DEPTH];

  idx_t     lkp_idx;
  logic     pred_resp_q, pred_taken_q, pred_taken_d;
  idx_t     pred_idx_q;
  logic     u1_valid_q, u1_taken_q;
  idx_t     u1_idx_q;
  logic     u2_valid_q, u2_taken_q;
  idx_t     u2_idx_q;
  pht_ctr_t cnt_q, cnt_d, u2_next;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc[PC_W-1:PHT_IDX_W+2], bus.pred_pc[1:0]};

`ifdef PHT_GSHARE_EN
  idx_t ghr_q;

  // History advances only when an update commits in U2, so it is never speculative.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (u2_valid_q) begin
      ghr_q <= {ghr_q[PHT_IDX_W-2:0], u2_taken_q};
    end
  end

  assign lkp_idx = bus.pred_pc[PHT_IDX_W+1:2] ^ ghr_q;
`else
  assign lkp_idx = bus.pred_pc[PHT_IDX_W+1:2];
`endif

  pht_sat_update u_sat (
    .cur_i  (cnt_q),
    .taken_i(u2_taken_q),
    .next_o (u2_next)
  );

  // Both readers bypass the array when U2 is writing the entry they want this cycle.
  always_comb begin
    cnt_d        = table_q[u1_idx_q];
    pred_taken_d = table_q[lkp_idx][1];
    if (u2_valid_q && (u2_idx_q == u1_idx_q)) cnt_d = u2_next;
    if (u2_valid_q && (u2_idx_q == lkp_idx)) pred_taken_d = u2_next[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= CTR_RESET;
    end else if (u2_valid_q) begin
      table_q[u2_idx_q] <= u2_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_resp_q  <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
      u1_valid_q   <= 1'b0;
      u1_idx_q     <= '0;
      u1_taken_q   <= 1'b0;
      u2_valid_q   <= 1'b0;
      u2_idx_q     <= '0;
      u2_taken_q   <= 1'b0;
      cnt_q        <= CTR_RESET;
    end else begin
      pred_resp_q <= bus.pred_valid;
      if (bus.pred_valid) begin
        pred_taken_q <= pred_taken_d;
        pred_idx_q   <= lkp_idx;
      end
      u1_valid_q <= bus.upd_valid;
      u1_idx_q   <= bus.upd_idx;
      u1_taken_q <= bus.upd_taken;
      u2_valid_q <= u1_valid_q;
      u2_idx_q   <= u1_idx_q;
      u2_taken_q <= u1_taken_q;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pred_resp  = pred_resp_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.pred_idx   = pred_idx_q;
  assign bus.upd_busy   = u1_valid_q | u2_valid_q;

endmodule

// File: tb/tb_pht_predictor.sv
// Scenario bench for pht_predictor with a reference counter table and expected-lookup queue.
module tb_pht_predictor;
  import pht_pkg::*;

  localparam int IW = 7;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          taken;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pht_predictor_if #(.PC_W(32), .PHT_IDX_W(IW)) bus ();

  pht_predictor #(.PC_W(32), .PHT_IDX_W(IW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  exp_t          exp_q[$];
  logic [1:0]    m_tab [128];
  logic [IW-1:0] m_ghr;
  logic          s1_v, s1_t, s2_v, s2_t;
  logic [IW-1:0] s1_i, s2_i;
  int            pass_cnt = 0;
  int            total_cnt = 0;

  function automatic logic [1:0] m_next(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  // PC whose lookup lands on idx given the current model history.
  function automatic logic [31:0] pc_for(input logic [IW-1:0] idx);
    logic [IW-1:0] k;
    k = idx;
`ifdef PHT_GSHARE_EN
    k = idx ^ m_ghr;
`endif
    return {23'd0, k, 2'b00};
  endfunction

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    bus.pred_valid = 1'b1; bus.pred_pc = 32'h44;
    bus.upd_valid = 1'b1;  bus.upd_idx = 7'd5; bus.upd_taken = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.pred_valid = 1'b0; bus.upd_valid = 1'b0;
    for (int i = 0; i < 128; i++) m_tab[i] = 2'b01;
    m_ghr = '0;
    s1_v = 1'b0; s2_v = 1'b0;
    exp_q.delete();
  endtask

  // One clock of stimulus; the model commits the U2 write before the lookup (write-first).
  task automatic step(input logic pv, input logic [31:0] pc,
                      input logic uv, input logic [IW-1:0] ui, input logic ut);
    exp_t e;
    bus.pred_valid = pv; bus.pred_pc = pc;
    bus.upd_valid = uv;  bus.upd_idx = ui; bus.upd_taken = ut;
    if (s2_v) m_tab[s2_i] = m_next(m_tab[s2_i], s2_t);
    if (pv) begin
      e.idx = pc[IW+1:2];
`ifdef PHT_GSHARE_EN
      e.idx = e.idx ^ m_ghr;
`endif
      e.taken = m_tab[e.idx][1];
      exp_q.push_back(e);
    end
`ifdef PHT_GSHARE_EN
    if (s2_v) m_ghr = {m_ghr[IW-2:0], s2_t};
`endif
    s2_v = s1_v; s2_i = s1_i; s2_t = s1_t;
    s1_v = uv;   s1_i = ui;   s1_t = ut;
    @(posedge clk); #1;
    bus.pred_valid = 1'b0; bus.upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    apply_reset(2);
    total_cnt++;
    if ({bus.pred_resp, bus.pred_taken, bus.pred_idx, bus.upd_busy} !== '0)
      $display("FAIL reset_outputs: resp=%0b taken=%0b idx=%0d busy=%0b, expected all 0",
               bus.pred_resp, bus.pred_taken, bus.pred_idx, bus.upd_busy);
    else pass_cnt++;
    step(1'b1, 32'h40, 1'b0, '0, 1'b0);
    e = exp_q.pop_front();
    total_cnt++;
    if (bus.pred_resp !== 1'b1 || bus.pred_taken !== 1'b0 || bus.pred_idx !== 7'd16 || e.idx !== 7'd16)
      $display("FAIL reset_lookup16: resp=%0b taken=%0b idx=%0d, expected resp=1 taken=0 idx=16",
               bus.pred_resp, bus.pred_taken, bus.pred_idx);
    else pass_cnt++;
    step(1'b0, 32'h0, 1'b0, '0, 1'b0);
    total_cnt++;
    if (bus.pred_resp !== 1'b0 || bus.pred_taken !== e.taken || bus.pred_idx !== e.idx)
      $display("FAIL idle_hold: resp=%0b taken=%0b idx=%0d, expected resp=0 taken=%0b idx=%0d",
               bus.pred_resp, bus.pred_taken, bus.pred_idx, e.taken, e.idx);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [1:0] pat [2] = '{2'b00, 2'b01};
    apply_reset(2);
    repeat (3) step(1'b0, 32'h0, 1'b1, 7'd16, 1'b1);
    total_cnt++;
    if (bus.upd_busy !== 1'b1) $display("FAIL busy_active: busy=%0b, expected 1", bus.upd_busy);
    else pass_cnt++;
    repeat (2) step(1'b0, 32'h0, 1'b0, '0, 1'b0);
    total_cnt++;
    if (bus.upd_busy !== 1'b0) $display("FAIL busy_drained: busy=%0b, expected 0", bus.upd_busy);
    else pass_cnt++;
    // Taken after three T (11), and still taken after one NT only if it had reached 11.
    for (int k = 0; k < 2; k++) begin
      if (pat[k][0]) begin
        step(1'b0, 32'h0, 1'b1, 7'd16, 1'b0);
        repeat (2) step(1'b0, 32'h0, 1'b0, '0, 1'b0);
      end
      step(1'b1, pc_for(7'd16), 1'b0, '0, 1'b0);
      e = exp_q.pop_front();
      total_cnt++;
      if (bus.pred_resp !== 1'b1 || bus.pred_taken !== 1'b1 || bus.pred_taken !== e.taken || bus.pred_idx !== e.idx)
        $display("FAIL b2b_lookup%0d: taken=%0b idx=%0d, expected taken=1 idx=%0d",
                 k, bus.pred_taken, bus.pred_idx, e.idx);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    // {update count, direction, expected prediction}
    int   cnt  [5] = '{5, 1, 5, 1, 1};
    logic dir  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic want [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset(2);
    for (int k = 0; k < 5; k++) begin
      repeat (cnt[k]) step(1'b0, 32'h0, 1'b1, 7'd3, dir[k]);
      repeat (2) step(1'b0, 32'h0, 1'b0, '0, 1'b0);
      step(1'b1, pc_for(7'd3), 1'b0, '0, 1'b0);
      e = exp_q.pop_front();
      total_cnt++;
      if (bus.pred_taken !== want[k] || bus.pred_taken !== e.taken || bus.pred_idx !== e.idx)
        $display("FAIL saturate_phase%0d: taken=%0b idx=%0d, expected taken=%0b idx=%0d",
                 k, bus.pred_taken, bus.pred_idx, want[k], e.idx);
      else pass_cnt++;
    end
  endtask

  task automatic test_collision();
    exp_t e;
    apply_reset(2);
    step(1'b0, 32'h0, 1'b1, 7'd16, 1'b1);
    step(1'b0, 32'h0, 1'b0, '0, 1'b0);
    step(1'b1, pc_for(7'd16), 1'b0, '0, 1'b0);
    e = exp_q.pop_front();
    total_cnt++;
    if (bus.pred_taken !== 1'b1 || bus.pred_taken !== e.taken || bus.pred_idx !== e.idx)
      $display("FAIL collision_write_first: taken=%0b idx=%0d, expected taken=1 idx=%0d",
               bus.pred_taken, bus.pred_idx, e.idx);
    else pass_cnt++;
  endtask

  task automatic test_independent();
    exp_t e;
    apply_reset(2);
    step(1'b0, 32'h0, 1'b1, 7'd9, 1'b1);
    step(1'b0, 32'h0, 1'b1, 7'd9, 1'b1);
    step(1'b1, pc_for(7'd5), 1'b1, 7'd9, 1'b1);
    e = exp_q.pop_front();
    total_cnt++;
    if (bus.pred_taken !== 1'b0 || bus.pred_taken !== e.taken || bus.pred_idx !== e.idx)
      $display("FAIL independent_idx: taken=%0b idx=%0d, expected taken=0 idx=%0d",
               bus.pred_taken, bus.pred_idx, e.idx);
    else pass_cnt++;
  endtask

  task automatic test_reset_flush();
    exp_t e;
    apply_reset(2);
    step(1'b0, 32'h0, 1'b1, 7'd16, 1'b1);
    apply_reset(1);
    total_cnt++;
    if (bus.upd_busy !== 1'b0) $display("FAIL flush_busy: busy=%0b, expected 0", bus.upd_busy);
    else pass_cnt++;
    repeat (3) step(1'b0, 32'h0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h40, 1'b0, '0, 1'b0);
    e = exp_q.pop_front();
    total_cnt++;
    if (bus.pred_taken !== 1'b0 || bus.pred_idx !== 7'd16 || e.taken !== 1'b0)
      $display("FAIL flush_dropped: taken=%0b idx=%0d, expected taken=0 idx=16",
               bus.pred_taken, bus.pred_idx);
    else pass_cnt++;
  endtask

  task automatic test_history();
    exp_t e;
    logic [IW-1:0] want_idx;
`ifdef PHT_GSHARE_EN
    want_idx = 7'd19;
`else
    want_idx = 7'd16;
`endif
    apply_reset(2);
    repeat (2) step(1'b0, 32'h0, 1'b1, 7'd0, 1'b1);
    repeat (2) step(1'b0, 32'h0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h40, 1'b0, '0, 1'b0);
    e = exp_q.pop_front();
    total_cnt++;
    if (bus.pred_idx !== want_idx || bus.pred_idx !== e.idx)
      $display("FAIL history_idx: idx=%0d, expected %0d", bus.pred_idx, want_idx);
    else pass_cnt++;
  endtask

  task automatic test_random();
    exp_t e;
    logic pv, uv, ut;
    logic [IW-1:0] ui;
    logic [31:0] pc;
    int bad;
    apply_reset(2);
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      pv = 1'($urandom_range(0, 1));
      uv = 1'($urandom_range(0, 3) != 0);
      ut = 1'($urandom_range(0, 1));
      ui = IW'($urandom_range(0, 3));
      pc = 32'($urandom_range(0, 3)) << 2;
      step(pv, pc, uv, ui, ut);
      if (pv) begin
        e = exp_q.pop_front();
        total_cnt++;
        if (bus.pred_resp !== 1'b1 || bus.pred_taken !== e.taken || bus.pred_idx !== e.idx) begin
          if (bad < 5)
            $display("FAIL random_lookup%0d: resp=%0b taken=%0b idx=%0d, expected resp=1 taken=%0b idx=%0d",
                     n, bus.pred_resp, bus.pred_taken, bus.pred_idx, e.taken, e.idx);
          bad++;
        end else pass_cnt++;
      end else begin
        total_cnt++;
        if (bus.pred_resp !== 1'b0) begin
          if (bad < 5) $display("FAIL random_idle%0d: resp=%0b, expected 0", n, bus.pred_resp);
          bad++;
        end else pass_cnt++;
      end
    end
  endtask

  initial begin
    bus.pred_valid = 1'b0; bus.pred_pc = '0;
    bus.upd_valid = 1'b0;  bus.upd_idx = '0; bus.upd_taken = 1'b0;
    test_reset();
    test_back_to_back();
    test_saturation();
    test_collision();
    test_independent();
    test_reset_flush();
    test_history();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
